mdu_sequencer: RTL
==================

Name: mdu_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide unit.
- Accepts one M-extension operation from the control path, then iterates a shift-add multiplier or a restoring divider, one bit per cycle.
- Applies sign correction, then presents the 32-bit result with a one-cycle done pulse.
- Core holds PC and the instruction while busy=1, and writes back on done.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request; sampled in IDLE or DONE only.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  DATA_WIDTH  rs1 value.
- op_b  input  DATA_WIDTH  rs2 value.
- kill  input  1  flush; aborts the current operation.
- busy  output  1  high in MUL, DIV and SIGN states.
- done  output  1  one-cycle pulse; result valid.
- result  output  DATA_WIDTH  final value; held until the next done.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset has priority over kill and start.
- States: IDLE, MUL, DIV, SIGN, DONE.
- IDLE or DONE with start=1:
  - Latch funct3.
  - Latch operand magnitudes: a is signed for MULH/MULHSU/DIV/REM; b is signed for MULH/DIV/REM.
  - Latch the negate flags.
  - counter=DATA_WIDTH.
  - Next state MUL (funct3[2]=0) or DIV (funct3[2]=1).
- Special cases, decided at start, go directly to DONE:
  - Divide by zero (b=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Special-case latency: done at cycle 1.
- MUL state: 2*DATA_WIDTH-bit accumulator. Each cycle, if the multiplier LSB=1, add the multiplicand to the upper half; then shift right 1. Decrement counter; when it reaches 1, next state SIGN.
- DIV state: restoring division. Each cycle, shift {rem,quot} left 1; trial-subtract the divisor; if non-negative keep the difference and set the quotient LSB. Same counter rule as MUL.
- SIGN state:
  - Product negated (64-bit two's complement) if the operand signs differ; for MULHSU only a's sign counts.
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Selection: MUL takes the low word; MULH/MULHSU/MULHU take the high word; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Register the selected word into result; next state DONE.
- DONE: done=1, busy=0. Next state IDLE, or a new op if start=1 (back-to-back; no idle bubble).
- Normal latency: start sampled at cycle 0; iterations run cycles 1..DATA_WIDTH; SIGN at cycle 33; done=1 at cycle 34.
- start while busy=1: ignored, with no effect on state or latched operands.
- kill=1 in any state: next state IDLE, busy=0 next cycle, done never asserted for the aborted op, result unchanged. kill and start in the same cycle: kill wins and the op is not accepted.
- Operands are captured only at acceptance; op_a/op_b changes during busy have no effect.
- Arithmetic wraps modulo 2^DATA_WIDTH. Internal adders are DATA_WIDTH+1 bits so carry/borrow is not lost.

Optional Feature:
- Macro: MDU_ZERO_SKIP_EN.
- Defined: any multiply (funct3[2]=0) with op_a=0 or op_b=0 goes directly to DONE with result=0, so done is at cycle 1.
- Undefined: zero operands take the full 34-cycle path and still produce 0.
- Divide behaviour is identical in both builds.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3): start at cycle 0 -> busy cycles 1-33, done at cycle 34, result=0xFFFFFFEB, done low at cycle 35.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done at cycle 1, 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done at cycle 1. REM same -> 0.
- Start MUL, assert kill at cycle 10 -> busy=0 at cycle 11, no done pulse, result keeps its prior value. A new start at cycle 12 completes normally at cycle 46.
- rst=0 asserted mid-DIV at cycle 20 -> next edge busy=0, done=0, result=0. Also: start asserted at cycle 5 of an in-flight op -> ignored, original result correct at cycle 34.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle sequencer for the RV32M multiply/divide unit.
// One operation is accepted in IDLE or DONE, iterated one bit per cycle
// (shift-add multiply or restoring divide), sign-corrected, and presented
// on result with a one-cycle done pulse.
// Optional feature: define MDU_ZERO_SKIP_EN to finish multiplies with a zero
// operand immediately (result 0, done in the cycle after acceptance).
module mdu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  kill,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SIGN, S_DONE} state_t;

  state_t              state, state_next, launch_state;
  logic [2:0]          f3_q;
  logic                a_neg_q, b_neg_q;
  logic [2*DW-1:0]     acc_q;      // {hi, lo} product or {rem, quot}
  logic [DW-1:0]       mcand_q;    // multiplicand or divisor magnitude
  logic [CNT_WIDTH-1:0] cnt_q;

  // Operand decode at acceptance
  logic          a_signed, b_signed, a_neg_in, b_neg_in;
  logic [DW-1:0] a_mag, b_mag;
  logic          div_zero, div_ovf, zero_skip, special, accept;
  logic [DW-1:0] special_val;

  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg_in = a_signed && op_a[DW-1];
  assign b_neg_in = b_signed && op_b[DW-1];
  assign a_mag    = a_neg_in ? -op_a : op_a;
  assign b_mag    = b_neg_in ? -op_b : op_b;

  assign div_zero = funct3[2] && (op_b == '0);
  // Only the signed forms (DIV=100, REM=110) can overflow.
  assign div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
`ifdef MDU_ZERO_SKIP_EN
  assign zero_skip = !funct3[2] && ((op_a == '0) || (op_b == '0));
`else
  assign zero_skip = 1'b0;
`endif
  assign special = div_zero || div_ovf || zero_skip;
  assign accept  = start && !kill && ((state == S_IDLE) || (state == S_DONE));

  // Result for operations that finish without iterating; funct3[1] marks REM/REMU
  always_comb begin
    special_val = '0;
    if (div_zero)     special_val = funct3[1] ? op_a : '1;
    else if (div_ovf) special_val = funct3[1] ? '0 : MIN_NEG;
  end

  // Single iteration steps
  logic [DW:0]     mul_sum, rem_sh, trial;
  logic            trial_ge;
  logic [2*DW-1:0] mul_next, div_next;

  assign mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[DW-1:1]};
  assign rem_sh   = {acc_q[2*DW-1:DW], acc_q[DW-1]};
  assign trial    = rem_sh - {1'b0, mcand_q};
  assign trial_ge = rem_sh >= {1'b0, mcand_q};
  assign div_next = trial_ge ? {trial[DW-1:0],  acc_q[DW-2:0], 1'b1}
                             : {rem_sh[DW-1:0], acc_q[DW-2:0], 1'b0};

  // Sign correction and word selection
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   quot_fix, rem_fix, sel_word;

  assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
  assign quot_fix = (a_neg_q ^ b_neg_q) ? -acc_q[DW-1:0] : acc_q[DW-1:0];
  assign rem_fix  = a_neg_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];

  // Pick the architectural word for the latched operation
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    sel_word = rem_fix;
    case (f3_q)
      3'b000:                 sel_word = prod_fix[DW-1:0];
      3'b001, 3'b010, 3'b011: sel_word = prod_fix[2*DW-1:DW];
      3'b100, 3'b101:         sel_word = quot_fix;
      default:                sel_word = rem_fix;
    endcase
  end

  assign launch_state = special ? S_DONE : (funct3[2] ? S_DIV : S_MUL);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state and status outputs; kill overrides everything
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:        state_next = accept ? launch_state : S_IDLE;
      S_MUL, S_DIV: begin
        busy = 1'b1;
        if (cnt_q == CNT_WIDTH'(1)) state_next = S_SIGN;
      end
      S_SIGN: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = accept ? launch_state : S_IDLE;
      end
      default:       state_next = S_IDLE;
    endcase
    if (kill) state_next = S_IDLE;
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (!rst) begin
      f3_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      result  <= '0;
    end else if (accept) begin
      f3_q    <= funct3;
      a_neg_q <= a_neg_in;
      b_neg_q <= b_neg_in;
      acc_q   <= {{DW{1'b0}}, a_mag};
      mcand_q <= b_mag;
      cnt_q   <= CNT_WIDTH'(DATA_WIDTH);
      if (special) result <= special_val;
    end else begin
      case (state)
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
        S_SIGN:  if (!kill) result <= sel_word;
        default: ;
      endcase
    end
  end

endmodule
